// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / run-control stage.
package fetch_pkg;

   // Default program counter width (1024-entry instruction memory).
   localparam int PC_W_DEF  = 10;
   // Default width of the signed relative branch displacement.
   localparam int OFF_W_DEF = 8;
   // Executed-cycle counter saturates here instead of wrapping.
   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   // Run-control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-address selector: halt > jump > taken branch > increment.
// All sums wrap silently modulo 2^PC_W.
module pc_next
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF
) (
   input  logic [PC_W-1:0]  pc,
   input  logic             halt,
   input  logic             jump,
   input  logic             branch,
   input  logic [OFF_W-1:0] offset,
   input  logic [PC_W-1:0]  target,
   input  logic             flag,
   input  logic             flip,
   output logic [PC_W-1:0]  next_pc
);

   logic [PC_W-1:0] offset_ext;
   logic            taken;

   // Sign-extend the displacement to PC width (or truncate if it is wider).
   generate
      if (PC_W > OFF_W) begin : g_ext
         assign offset_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
      end else begin : g_trunc
         assign offset_ext = offset[PC_W-1:0];
      end
   endgenerate

   // A branch is taken only when the flag register reports flag ^ flip.
   assign taken = branch & (flag ^ flip);

   // Priority mux over the four next-address sources.
   always_comb begin
      next_pc = pc + PC_W'(1);
      if (halt) begin
         next_pc = pc;
      end else if (jump) begin
         next_pc = target;
      end else if (taken) begin
         next_pc = pc + offset_ext;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and IDLE/RUN/DONE run control for the single-cycle CPU,
// with a saturating count of executed RUN cycles.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int OFF_W      = OFF_W_DEF,
   parameter int START_ADDR = 0
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             jump,
   input  logic             branch,
   input  logic [OFF_W-1:0] offset,
   input  logic [PC_W-1:0]  target,
   input  logic             flag,
   input  logic             flip,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             done,
   output logic [15:0]      cycleCount
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   state_t          state_reg;
   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next_w;
   logic [15:0]     count_reg;
   logic            running_reg;
   logic            done_reg;

   pc_next #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_pc_next (
      .pc      (pc_reg),
      .halt    (halt),
      .jump    (jump),
      .branch  (branch),
      .offset  (offset),
      .target  (target),
      .flag    (flag),
      .flip    (flip),
      .next_pc (pc_next_w)
   );

   // Run-control FSM owning the PC, the cycle counter and the status flags.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg   <= IDLE;
         pc_reg      <= START_PC;
         count_reg   <= '0;
         running_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               pc_reg <= START_PC;
               if (start) begin
                  state_reg   <= RUN;
                  count_reg   <= '0;
                  running_reg <= 1'b1;
                  done_reg    <= 1'b0;
               end
            end
            RUN: begin
               // The halt cycle counts as an executed cycle too.
               pc_reg <= pc_next_w;
               if (count_reg != COUNT_MAX) begin
                  count_reg <= count_reg + 16'd1;
               end
               if (halt) begin
                  state_reg   <= DONE;
                  running_reg <= 1'b0;
                  done_reg    <= 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  state_reg   <= RUN;
                  pc_reg      <= START_PC;
                  count_reg   <= '0;
                  running_reg <= 1'b1;
                  done_reg    <= 1'b0;
               end
            end
            default: begin
               state_reg   <= IDLE;
               pc_reg      <= START_PC;
               count_reg   <= '0;
               running_reg <= 1'b0;
               done_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign pc         = pc_reg;
   assign running    = running_reg;
   assign done       = done_reg;
   assign cycleCount = count_reg;

endmodule
